// File: rtl/wb_nto1_arbiter.sv
// Round-robin N-to-1 Wishbone arbiter. Bursts are never split, a transfer
// quantum bounds ownership, and a watchdog ends stalled slave accesses with ERR.
module wb_nto1_arbiter #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int QUANTUM        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W = WB_DATA_WIDTH / 8,
  localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WB_ADDR_WIDTH-1:0] ADR    [N_MASTERS-1:0],
  input  logic [WB_DATA_WIDTH-1:0] DAT_W  [N_MASTERS-1:0],
  input  logic [2:0]               CTI    [N_MASTERS-1:0],
  input  logic [1:0]               BTE    [N_MASTERS-1:0],
  input  logic [SEL_W-1:0]         SEL    [N_MASTERS-1:0],
  input  logic                     CYC    [N_MASTERS-1:0],
  input  logic                     STB    [N_MASTERS-1:0],
  input  logic                     WE     [N_MASTERS-1:0],
  output logic [WB_DATA_WIDTH-1:0] DAT_R  [N_MASTERS-1:0],
  output logic                     ACK    [N_MASTERS-1:0],
  output logic                     ERR    [N_MASTERS-1:0],
  output logic [WB_ADDR_WIDTH-1:0] SADR,
  output logic [WB_DATA_WIDTH-1:0] SDAT_W,
  output logic [2:0]               SCTI,
  output logic [1:0]               SBTE,
  output logic [SEL_W-1:0]         SSEL,
  output logic                     SCYC,
  output logic                     SSTB,
  output logic                     SWE,
  input  logic [WB_DATA_WIDTH-1:0] SDAT_R,
  input  logic                     SACK,
  input  logic                     SERR,
  output logic                     gnt_valid,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     timeout_pulse
);

  localparam int XW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN, TMO, REL} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] last_owner_q, last_owner_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [XW-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;

  logic [N_MASTERS-1:0] req, others;
  logic [ID_W-1:0]      pick_id, cand;
  logic                 pick_vld;
  logic                 own, resp, stall, tmo_hit, boundary, yield;

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) req[i] = CYC[i] & STB[i];
    others = req;
    others[gnt_id_q] = 1'b0;
  end

  // Descending scan: the last hit is the first requester after last_owner.
  always_comb begin
    pick_id  = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = ID_W'((int'(last_owner_q) + k) % N_MASTERS);
      if (req[cand]) begin
        pick_id  = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign own      = (state_q == OWN);
  assign resp     = own & (SACK | SERR);
  assign stall    = own & STB[gnt_id_q] & ~SACK & ~SERR;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && stall &&
                    (int'(wait_cnt_q) + 1 >= TIMEOUT_CYCLES);
  assign boundary = (CTI[gnt_id_q] == 3'b000) || (CTI[gnt_id_q] == 3'b111);
  assign yield    = (QUANTUM != 0) && own && SACK && boundary && (|others) &&
                    (int'(xfer_cnt_q) + 1 >= QUANTUM);

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    last_owner_d = last_owner_q;
    xfer_cnt_d   = xfer_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d     = OWN;
        gnt_id_d    = pick_id;
        gnt_valid_d = 1'b1;
        xfer_cnt_d  = '0;
        wait_cnt_d  = '0;
      end
      OWN: begin
        if (resp) begin
          if (xfer_cnt_q != '1) xfer_cnt_d = xfer_cnt_q + 1'b1;
          wait_cnt_d = '0;
        end else if (stall && wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // CYC drop outranks a coincident watchdog expiry.
        if (!CYC[gnt_id_q]) begin
          state_d     = REL;
          gnt_valid_d = 1'b0;
        end else if (tmo_hit) begin
          state_d = TMO;
        end else if (yield) begin
          state_d     = REL;
          gnt_valid_d = 1'b0;
        end
      end
      TMO: begin
        state_d     = REL;
        gnt_valid_d = 1'b0;
      end
      REL: begin
        state_d      = IDLE;
        last_owner_d = gnt_id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      last_owner_q <= ID_W'(N_MASTERS - 1);
      xfer_cnt_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      last_owner_q <= last_owner_d;
      xfer_cnt_q   <= xfer_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    SADR   = '0;
    SDAT_W = '0;
    SCTI   = '0;
    SBTE   = '0;
    SSEL   = '0;
    SCYC   = 1'b0;
    SSTB   = 1'b0;
    SWE    = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      DAT_R[i] = '0;
      ACK[i]   = 1'b0;
      ERR[i]   = 1'b0;
    end
    if (own) begin
      SADR            = ADR[gnt_id_q];
      SDAT_W          = DAT_W[gnt_id_q];
      SCTI            = CTI[gnt_id_q];
      SBTE            = BTE[gnt_id_q];
      SSEL            = SEL[gnt_id_q];
      SCYC            = CYC[gnt_id_q];
      SSTB            = STB[gnt_id_q];
      SWE             = WE[gnt_id_q];
      DAT_R[gnt_id_q] = SDAT_R;
      ACK[gnt_id_q]   = SACK;
      ERR[gnt_id_q]   = SERR;
    end
    if (state_q == TMO) ERR[gnt_id_q] = 1'b1;
  end

  assign gnt_valid     = gnt_valid_q;
  assign gnt_id        = gnt_id_q;
  assign timeout_pulse = (state_q == TMO);

endmodule
